// File: rtl/tt_seq_pkg.sv
// Shared definitions for the truth-table sequencer.
// Holds the controller state encoding, the sweep geometry and the
// settle-timer width used by truth_table_sequencer and tt_settle_timer.
package tt_seq_pkg;

    localparam int unsigned ROWS          = 16;
    localparam int unsigned IN_W          = 4;
    localparam int unsigned OUT_W_DEFAULT = 10;
    localparam int unsigned TIMER_W       = 8;

    localparam logic [IN_W-1:0] LAST_ROW = IN_W'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        PRESENT,
        DONE
    } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: 8-bit load/decrement down-counter with a zero flag.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (count -> 0)
//   load_i     load load_val_i (has priority over dec_i)
//   load_val_i value to load
//   dec_i      decrement by one; holds at zero
//   zero_o     count is zero
module tt_settle_timer
    import tt_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks the 16 combinations of {w,x,y,z}, holds each
// for SETTLE_CYCLES clocks, samples the breadboard results r_in and emits
// one captured row per combination on a valid/ready stream.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a sweep (sampled only when idle)
//   busy              sweep in progress (APPLY..DONE)
//   w, x, y, z        breadboard stimulus, w = MSB of the row number
//   r_in              breadboard results
//   row_valid/ready   captured-row handshake
//   row_index         row number 0..15
//   row_inputs        {w,x,y,z} applied for the row
//   row_outputs       r_in sampled at the end of settle
//   done              one-cycle pulse after row 15 is accepted
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 6,
    parameter int unsigned OUT_W         = OUT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             w,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic [OUT_W-1:0] r_in,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [IN_W-1:0]  row_index,
    output logic [IN_W-1:0]  row_inputs,
    output logic [OUT_W-1:0] row_outputs,
    output logic             done
);

    // Timer reaches zero on the last settle cycle, so it starts at S-1.
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    idx_q, idx_d;
    logic [IN_W-1:0]    stim_q, stim_d;
    logic [IN_W-1:0]    row_idx_q, row_idx_d;
    logic [IN_W-1:0]    row_in_q, row_in_d;
    logic [OUT_W-1:0]   row_out_q, row_out_d;
    logic               timer_load;
    logic               timer_dec;
    logic               timer_zero;

    tt_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stim_d     = stim_q;
        row_idx_d  = row_idx_q;
        row_in_d   = row_in_q;
        row_out_d  = row_out_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                stim_d     = idx_q;
                timer_load = 1'b1;
                state_d    = SETTLE;
            end
            SETTLE: begin
                if (timer_zero) begin
                    row_idx_d = idx_q;
                    row_in_d  = idx_q;
                    row_out_d = r_in;
                    state_d   = PRESENT;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            PRESENT: begin
                if (row_ready) begin
                    if (idx_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IN_W'(1);
                        state_d = APPLY;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            stim_q    <= '0;
            row_idx_q <= '0;
            row_in_q  <= '0;
            row_out_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stim_q    <= stim_d;
            row_idx_q <= row_idx_d;
            row_in_q  <= row_in_d;
            row_out_q <= row_out_d;
        end
    end

    // Row valid is exactly the PRESENT state, which also keeps it
    // mutually exclusive with done.
    assign row_valid   = (state_q == PRESENT);
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign w           = stim_q[3];
    assign x           = stim_q[2];
    assign y           = stim_q[1];
    assign z           = stim_q[0];
    assign row_index   = row_idx_q;
    assign row_inputs  = row_in_q;
    assign row_outputs = row_out_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
`timescale 1ns/1ps
module tb_truth_table_sequencer;

    localparam int unsigned OW = 10;

    typedef struct {
        logic [3:0]    idx;
        logic [OW-1:0] out;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start_a, start_b, ready_a, ready_b;
    logic          busy_a, w_a, x_a, y_a, z_a, valid_a, done_a;
    logic          busy_b, w_b, x_b, y_b, z_b, valid_b, done_b;
    logic [3:0]    idx_a, in_a, idx_b, in_b;
    logic [OW-1:0] out_a, out_b, r_a, r_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   e0_a = 0, e0_b = 0;
    int   first_rel_a = -1, first_rel_b = -1;
    int   done_rel_a = -1, done_rel_b = -1;
    int   done_cnt_a = 0, done_cnt_b = 0;
    logic period_chk_a = 1'b0;

    // Breadboard model: row 0 -> 000, row 5 -> 002, row 15 -> 003.
    function automatic logic [OW-1:0] bb(input logic [3:0] v);
        logic a, b, c, d;
        logic [OW-1:0] r;
        {a, b, c, d} = v;
        r    = '0;
        r[0] = a & b & c & d;
        r[1] = b & d;
        r[2] = a & ~b;
        r[3] = c & ~d;
        r[4] = ~a & ~b & c;
        r[5] = (a ^ d) & ~b;
        r[6] = (a | b | c | d) & ~(b & d);
        r[7] = c & ~a & ~d;
        r[8] = a & ~d;
        r[9] = b & ~c & ~d;
        return r;
    endfunction

    assign r_a = bb({w_a, x_a, y_a, z_a});
    assign r_b = bb({w_b, x_b, y_b, z_b});

    truth_table_sequencer #(.SETTLE_CYCLES(6), .OUT_W(OW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
        .w(w_a), .x(x_a), .y(y_a), .z(z_a), .r_in(r_a),
        .row_valid(valid_a), .row_ready(ready_a), .row_index(idx_a),
        .row_inputs(in_a), .row_outputs(out_a), .done(done_a)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1), .OUT_W(OW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
        .w(w_b), .x(x_b), .y(y_b), .z(z_b), .r_in(r_b),
        .row_valid(valid_b), .row_ready(ready_b), .row_index(idx_b),
        .row_inputs(in_b), .row_outputs(out_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_a();
        exp_t e;
        logic prev_v   = 1'b0;
        int   last_acc = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v   = 1'b0;
                last_acc = -1;
                continue;
            end
            if (valid_a && !prev_v && idx_a == 4'd0) first_rel_a = cyc - e0_a + 1;
            prev_v = valid_a;
            if (done_a) begin
                done_cnt_a++;
                done_rel_a = cyc - e0_a + 1;
                chk("a_done_excl_valid", {31'd0, valid_a}, 0);
            end
            if (valid_a) chk("a_stim_eq_index", {w_a, x_a, y_a, z_a}, idx_a);
            if (valid_a && ready_a) begin
                chk("a_sb_nonempty", sb_a.size() != 0, 1);
                if (sb_a.size() != 0) begin
                    e = sb_a.pop_front();
                    chk("a_row_index", idx_a, e.idx);
                    chk("a_row_inputs", in_a, e.idx);
                    chk("a_row_outputs", out_a, e.out);
                    if (e.idx == 4'd0)  chk("a_row0_out", out_a, 10'h000);
                    if (e.idx == 4'd5)  chk("a_row5_out", out_a, 10'h002);
                    if (e.idx == 4'd15) chk("a_row15_out", out_a, 10'h003);
                    if (period_chk_a && e.idx != 4'd0 && last_acc >= 0)
                        chk("a_row_period", cyc - last_acc, 8);
                end
                last_acc = cyc;
            end
        end
    endtask

    task automatic mon_b();
        exp_t e;
        logic prev_v   = 1'b0;
        int   last_acc = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v   = 1'b0;
                last_acc = -1;
                continue;
            end
            if (valid_b && !prev_v && idx_b == 4'd0) first_rel_b = cyc - e0_b + 1;
            prev_v = valid_b;
            if (done_b) begin
                done_cnt_b++;
                done_rel_b = cyc - e0_b + 1;
            end
            if (valid_b && ready_b) begin
                chk("b_sb_nonempty", sb_b.size() != 0, 1);
                if (sb_b.size() != 0) begin
                    e = sb_b.pop_front();
                    chk("b_row_index", idx_b, e.idx);
                    chk("b_row_outputs", out_b, e.out);
                    if (e.idx != 4'd0 && last_acc >= 0) chk("b_row_period", cyc - last_acc, 3);
                end
                last_acc = cyc;
            end
        end
    endtask

    initial begin
        exp_t e;
        int   base;
        logic found;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        fork
            mon_a();
            mon_b();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("a_reset_busy", {31'd0, busy_a}, 0);
        chk("a_reset_valid", {31'd0, valid_a}, 0);
        chk("a_reset_done", {31'd0, done_a}, 0);
        chk("a_reset_stim", {w_a, x_a, y_a, z_a}, 0);
        chk("a_reset_rows", {idx_a, in_a, out_a}, 0);
        chk("b_reset_state", {busy_b, valid_b, done_b, w_b, x_b, y_b, z_b}, 0);

        // Full sweep on both builds, ready held high
        for (int i = 0; i < 16; i++) begin
            e.idx = 4'(i);
            e.out = bb(4'(i));
            sb_a.push_back(e);
            sb_b.push_back(e);
        end
        period_chk_a = 1'b1;
        base = done_cnt_a;
        @(posedge clk); #1;
        start_a = 1'b1; start_b = 1'b1;
        e0_a = cyc + 1; e0_b = cyc + 1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 300 && done_cnt_a == base; i++) @(negedge clk);
        @(posedge clk); #1;
        chk("a_sweep1_done_count", done_cnt_a - base, 1);
        chk("a_done_cycle", done_rel_a, 129);
        chk("a_first_valid_cycle", first_rel_a, 8);
        chk("a_sweep1_all_rows", sb_a.size(), 0);
        chk("b_done_count", done_cnt_b, 1);
        chk("b_done_cycle", done_rel_b, 49);
        chk("b_first_valid_cycle", first_rel_b, 3);
        chk("b_all_rows", sb_b.size(), 0);
        period_chk_a = 1'b0;

        // Back-pressure on row 3, start pulsed again at row 7
        for (int i = 0; i < 16; i++) begin
            e.idx = 4'(i);
            e.out = bb(4'(i));
            sb_a.push_back(e);
        end
        base = done_cnt_a;
        start_a = 1'b1; e0_a = cyc + 1;
        @(posedge clk); #1;
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (valid_a && idx_a == 4'd3) found = 1'b1;
        end
        chk("a_row3_reached", {31'd0, found}, 1);
        ready_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("a_bp_hold", {valid_a, idx_a, in_a, out_a, w_a, x_a, y_a, z_a},
                {1'b1, 4'd3, 4'd3, bb(4'd3), 4'd3});
        end
        @(posedge clk); #1;
        ready_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if ({w_a, x_a, y_a, z_a} == 4'd7) found = 1'b1;
        end
        chk("a_row7_reached", {31'd0, found}, 1);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 200 && done_cnt_a == base; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("a_sweep2_one_done", done_cnt_a - base, 1);
        chk("a_sweep2_idle", {31'd0, busy_a}, 0);
        chk("a_sweep2_all_rows", sb_a.size(), 0);

        // Reset during SETTLE of row 9, start asserted with reset
        for (int i = 0; i < 16; i++) begin
            e.idx = 4'(i);
            e.out = bb(4'(i));
            sb_a.push_back(e);
        end
        @(posedge clk); #1;
        start_a = 1'b1; e0_a = cyc + 1;
        @(posedge clk); #1;
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if ({w_a, x_a, y_a, z_a} == 4'd9 && !valid_a && busy_a) found = 1'b1;
        end
        chk("a_row9_settle_reached", {31'd0, found}, 1);
        rst = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        sb_a.delete();
        chk("a_midreset_outputs",
            {busy_a, valid_a, done_a, w_a, x_a, y_a, z_a, idx_a, in_a, out_a}, 0);
        rst = 1'b0; start_a = 1'b0;
        @(posedge clk); #1;
        chk("a_start_with_rst_ignored", {31'd0, busy_a}, 0);

        for (int i = 0; i < 16; i++) begin
            e.idx = 4'(i);
            e.out = bb(4'(i));
            sb_a.push_back(e);
        end
        base = done_cnt_a;
        start_a = 1'b1; e0_a = cyc + 1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 300 && done_cnt_a == base; i++) @(negedge clk);
        @(posedge clk); #1;
        chk("a_sweep3_done_count", done_cnt_a - base, 1);
        chk("a_sweep3_first_valid", first_rel_a, 8);
        chk("a_sweep3_all_rows", sb_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
